// File: rtl/mac_fetch_ctrl_if.sv
// Control/read bundle between mac_fetch_ctrl and the mac plus its ia/weight row memories.
// master = fetch controller, slave = mac/memory side.
interface mac_fetch_ctrl_if #(
  parameter int IA_ROW_MEM_ADDR     = 7,
  parameter int WEIGHT_ROW_MEM_ADDR = 8
);
  logic                           mac_start;
  logic                           mac_resetn;
  logic                           ia_need;
  logic                           weight_need;
  logic                           ia_rd_en;
  logic [IA_ROW_MEM_ADDR-1:0]     ia_rd_addr;
  logic                           wt_rd_en;
  logic [WEIGHT_ROW_MEM_ADDR-1:0] wt_rd_addr;
  logic                           row_done;

  modport master (
    input  ia_need, weight_need,
    output mac_start, mac_resetn, ia_rd_en, ia_rd_addr, wt_rd_en, wt_rd_addr, row_done
  );

  modport slave (
    output ia_need, weight_need,
    input  mac_start, mac_resetn, ia_rd_en, ia_rd_addr, wt_rd_en, wt_rd_addr, row_done
  );
endinterface

// File: rtl/mac_fetch_ctrl.sv
// Sequences one mac through a tile of output rows: config check, shift-register prime,
// need-driven row-memory reads, drain and mac clear.
//   state   | meaning
//   S_IDLE  | waiting for start; config latched on start
//   S_CHECK | validate latched config; mac_start or cfg_err+done
//   S_PRIME | 3 lockstep reads (addr 0,1,2) to fill the mac shift registers
//   S_RUN   | reads follow ia_need/weight_need until OUT_ROWS rows are read
//   S_DRAIN | DRAIN_CYC idle cycles for the mac pipeline to empty
//   S_CLEAR | mac_resetn low for one cycle, done registered
module mac_fetch_ctrl #(
  parameter int IA_ROW_MEM_ADDR     = 7,
  parameter int WEIGHT_ROW_MEM_ADDR = 8,
  parameter int ROW_CNT_W           = 6,
  parameter int DRAIN_CYC           = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [2:0]           i_k,
  input  logic [5:0]           i_img_w,
  input  logic [7:0]           i_oc,
  input  logic [2:0]           i_stride,
  input  logic [ROW_CNT_W-1:0] i_out_rows,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cfg_err,
  mac_fetch_ctrl_if.master     mac_if
);
  localparam int IAW   = IA_ROW_MEM_ADDR;
  localparam int WAW   = WEIGHT_ROW_MEM_ADDR;
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PRIME, S_RUN, S_DRAIN, S_CLEAR} state_t;

  state_t               r_state, w_next;
  logic [2:0]           r_k, r_stride, r_k_idx;
  logic [5:0]           r_img_w;
  logic [7:0]           r_oc, r_oc_idx;
  logic [ROW_CNT_W-1:0] r_out_rows, r_row_cnt;
  logic [IAW-1:0]       r_ia_idx;
  logic [DRN_W-1:0]     r_drain_cnt;
  logic                 r_done, r_cfg_err;

  logic                 w_legal, w_row_wrap, w_last_row, w_oc_wrap, w_k_wrap;
  logic                 w_ia_rd, w_wt_rd, w_mac_start, w_clear;
  logic [WAW-1:0]       w_wt_run_addr, w_wt_addr;

  assign w_legal = (r_k >= 3'd1) && (r_k <= 3'd3) &&
                   (r_img_w >= 6'd4) && (r_img_w <= 6'd32) &&
                   (r_oc >= 8'd1) && (r_oc <= 8'd64) &&
                   ((r_stride == 3'd1) || (r_stride == 3'd2)) &&
                   (r_out_rows != '0);

  assign w_row_wrap    = (r_ia_idx == IAW'(r_img_w - 6'd1));
  assign w_last_row    = ((r_row_cnt + ROW_CNT_W'(1)) == r_out_rows);
  assign w_oc_wrap     = (r_oc_idx == (r_oc - 8'd1));
  assign w_k_wrap      = (r_k_idx == (r_k - 3'd1));
  // Product wraps modulo the weight address space.
  assign w_wt_run_addr = WAW'(r_oc_idx) * WAW'(r_k) + WAW'(r_k_idx);

  always_comb begin
    w_next      = r_state;
    w_mac_start = 1'b0;
    w_clear     = 1'b0;
    w_ia_rd     = 1'b0;
    w_wt_rd     = 1'b0;
    w_wt_addr   = w_wt_run_addr;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CHECK;
      S_CHECK: begin
        if (w_legal) begin
          w_mac_start = 1'b1;
          w_next      = S_PRIME;
        end else begin
          w_next      = S_IDLE;
        end
      end
      S_PRIME: begin
        w_ia_rd   = 1'b1;
        w_wt_rd   = 1'b1;
        w_wt_addr = WAW'(r_ia_idx);
        if (r_ia_idx == IAW'(2)) w_next = S_RUN;
      end
      S_RUN: begin
        w_ia_rd = mac_if.ia_need;
        w_wt_rd = mac_if.weight_need;
        if (w_ia_rd && w_row_wrap && w_last_row) w_next = S_DRAIN;
      end
      S_DRAIN: if (r_drain_cnt == '0) w_next = S_CLEAR;
      S_CLEAR: begin
        w_clear = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_stride    <= '0;
      r_img_w     <= '0;
      r_oc        <= '0;
      r_out_rows  <= '0;
      r_ia_idx    <= '0;
      r_oc_idx    <= '0;
      r_k_idx     <= '0;
      r_row_cnt   <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k        <= i_k;
            r_stride   <= i_stride;
            r_img_w    <= i_img_w;
            r_oc       <= i_oc;
            r_out_rows <= i_out_rows;
          end
        end
        S_CHECK: begin
          if (w_legal) begin
            r_cfg_err <= 1'b0;
            r_ia_idx  <= '0;
            r_oc_idx  <= '0;
            r_k_idx   <= '0;
            r_row_cnt <= '0;
          end else begin
            r_cfg_err <= 1'b1;
            r_done    <= 1'b1;
          end
        end
        S_PRIME: r_ia_idx <= r_ia_idx + IAW'(1);
        S_RUN: begin
          if (w_ia_rd) begin
            if (w_row_wrap) begin
              r_ia_idx  <= '0;
              r_row_cnt <= r_row_cnt + ROW_CNT_W'(1);
            end else begin
              r_ia_idx  <= r_ia_idx + IAW'(1);
            end
          end
          if (w_wt_rd) begin
            if (w_oc_wrap) begin
              r_oc_idx <= '0;
              r_k_idx  <= w_k_wrap ? 3'd0 : r_k_idx + 3'd1;
            end else begin
              r_oc_idx <= r_oc_idx + 8'd1;
            end
          end
          if (w_next == S_DRAIN) r_drain_cnt <= DRN_W'(DRAIN_CYC - 1);
        end
        S_DRAIN: r_drain_cnt <= r_drain_cnt - DRN_W'(1);
        S_CLEAR: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = r_done;
  assign o_cfg_err         = r_cfg_err;
  assign mac_if.mac_start  = w_mac_start;
  assign mac_if.mac_resetn = ~(i_reset | w_clear);
  assign mac_if.ia_rd_en   = w_ia_rd;
  assign mac_if.ia_rd_addr = r_ia_idx;
  assign mac_if.wt_rd_en   = w_wt_rd;
  assign mac_if.wt_rd_addr = w_wt_addr;
  assign mac_if.row_done   = (r_state == S_RUN) && w_ia_rd && w_row_wrap;
endmodule

// File: tb/tb_mac_fetch_ctrl.sv
// Randomized bench for mac_fetch_ctrl; expected outputs come from a per-job
// timeline model (read counts, cycle offsets from start) rather than FSM state.
module tb_mac_fetch_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] k, stride;
  logic [5:0] img_w, out_rows;
  logic [7:0] oc;
  logic       busy, done, cfg_err;

  int n_chk = 0;
  int n_bad = 0;
  bit exp_cfg_err = 1'b0;

  always #5 clk = ~clk;

  mac_fetch_ctrl_if u_if ();

  mac_fetch_ctrl u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_k        (k),
    .i_img_w    (img_w),
    .i_oc       (oc),
    .i_stride   (stride),
    .i_out_rows (out_rows),
    .o_busy     (busy),
    .o_done     (done),
    .o_cfg_err  (cfg_err),
    .mac_if     (u_if)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pins();
    k        = 3'($urandom);
    img_w    = 6'($urandom);
    oc       = 8'($urandom);
    stride   = 3'($urandom);
    out_rows = 6'($urandom);
  endtask

  task automatic chk_outs(input string p, input bit e_busy, input bit e_done, input bit e_err,
                          input bit e_ms, input bit e_rstn, input bit e_ia, input bit e_wt,
                          input bit e_rd, input int e_ia_a, input int e_wt_a);
    @(negedge clk);
    chk({p, "busy"},       int'(busy),            int'(e_busy));
    chk({p, "done"},       int'(done),            int'(e_done));
    chk({p, "cfg_err"},    int'(cfg_err),         int'(e_err));
    chk({p, "mac_start"},  int'(u_if.mac_start),  int'(e_ms));
    chk({p, "mac_resetn"}, int'(u_if.mac_resetn), int'(e_rstn));
    chk({p, "ia_rd_en"},   int'(u_if.ia_rd_en),   int'(e_ia));
    chk({p, "wt_rd_en"},   int'(u_if.wt_rd_en),   int'(e_wt));
    chk({p, "row_done"},   int'(u_if.row_done),   int'(e_rd));
    if (e_ia) chk({p, "ia_rd_addr"}, int'(u_if.ia_rd_addr), e_ia_a);
    if (e_wt) chk({p, "wt_rd_addr"}, int'(u_if.wt_rd_addr), e_wt_a);
  endtask

  // One job from start pulse to the idle cycle after done.
  task automatic run_job(input int kk, input int ww, input int occ, input int ss, input int rr,
                         input int ia_pct, input int wt_pct, input int poke_pct,
                         output int n_ia, output int n_rd);
    bit legal, eb, ni, nw, prime, run, ei, ew, ed, ems, ern, finished;
    int total, ia_cnt, m, t_last, t_done, c, ea, wa;
    legal = (kk >= 1) && (kk <= 3) && (ww >= 4) && (ww <= 32) && (occ >= 1) && (occ <= 64) &&
            ((ss == 1) || (ss == 2)) && (rr >= 1);
    total = rr * ww;
    ia_cnt = 0; m = 0; t_last = -1; n_ia = 0; n_rd = 0; finished = 1'b0;
    start = 1'b1; k = 3'(kk); img_w = 6'(ww); oc = 8'(occ); stride = 3'(ss); out_rows = 6'(rr);
    u_if.ia_need = 1'($urandom); u_if.weight_need = 1'($urandom);
    chk_outs("start ", 1'b0, 1'b0, exp_cfg_err, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    next_cyc();
    for (c = 1; c < 6000; c++) begin
      t_done = legal ? ((t_last >= 0) ? t_last + 6 : -1) : 2;
      eb = legal ? ((t_last < 0) || (c <= t_last + 5)) : (c == 1);
      ni = ($urandom_range(0, 99) < ia_pct);
      nw = ($urandom_range(0, 99) < wt_pct);
      u_if.ia_need = ni;
      u_if.weight_need = nw;
      rand_pins();
      start = eb && ($urandom_range(0, 99) < poke_pct);
      prime = legal && (c >= 2) && (c <= 4);
      run   = legal && (c >= 5) && (t_last < 0);
      ei    = prime || (run && ni);
      ew    = prime || (run && nw);
      ea    = ia_cnt % ww;
      ed    = ei && (ea == ww - 1);
      wa    = prime ? c - 2 : ((((m % occ) * kk) + ((m / occ) % kk)) % 256);
      ems   = legal && (c == 1);
      ern   = !(legal && (t_last >= 0) && (c == t_last + 5));
      if (c == 2) exp_cfg_err = !legal;
      chk_outs("job ", eb, (c == t_done), exp_cfg_err, ems, ern, ei, ew, ed, ea, wa);
      if (u_if.ia_rd_en) n_ia++;
      if (u_if.row_done) n_rd++;
      if (ei) begin
        ia_cnt++;
        if (ia_cnt == total) t_last = c;
      end
      if (run && ew) m++;
      if (c == t_done) begin
        finished = 1'b1;
        break;
      end
      next_cyc();
    end
    if (!finished) chk("job cycle budget", c, -1);
    next_cyc();
    start = 1'b0;
    chk_outs("after ", 1'b0, 1'b0, exp_cfg_err, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    next_cyc();
  endtask

  task automatic reset_mid_run();
    start = 1'b1; k = 3'd2; img_w = 6'd16; oc = 8'd3; stride = 3'd2; out_rows = 6'd4;
    u_if.ia_need = 1'b1; u_if.weight_need = 1'b1;
    next_cyc();
    start = 1'b0;
    repeat (6) next_cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("rst mid busy before edge", int'(busy), 1);
    chk("rst mid mac_resetn", int'(u_if.mac_resetn), 0);
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      chk_outs("rst mid ", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    next_cyc();
    reset = 1'b0;
    exp_cfg_err = 1'b0;
    chk_outs("rst rel ", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    next_cyc();
    chk_outs("rst rel2 ", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    next_cyc();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nia, nrd, kk, ww, occ, ss, rr;
    reset = 1'b1; start = 1'b0; k = '0; img_w = '0; oc = '0; stride = '0; out_rows = '0;
    u_if.ia_need = 1'b0; u_if.weight_need = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_outs("reset ", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      chk("reset ia_rd_addr", int'(u_if.ia_rd_addr), 0);
      chk("reset wt_rd_addr", int'(u_if.wt_rd_addr), 0);
      next_cyc();
    end
    reset = 1'b0;
    next_cyc();

    run_job(3, 4, 2, 1, 1, 100, 100, 0, nia, nrd);
    chk("basic row_done count", nrd, 1);
    run_job(3, 32, 2, 1, 1, 40, 100, 0, nia, nrd);
    run_job(1, 8, 5, 2, 3, 60, 50, 0, nia, nrd);
    chk("3-row ia reads", nia, 24);
    chk("3-row row_done count", nrd, 3);

    run_job(0, 8, 4, 1, 2, 50, 50, 0, nia, nrd);
    run_job(2, 8, 4, 3, 2, 50, 50, 0, nia, nrd);
    run_job(2, 3, 4, 1, 2, 50, 50, 0, nia, nrd);
    run_job(2, 33, 4, 1, 2, 50, 50, 0, nia, nrd);
    run_job(2, 8, 0, 1, 2, 50, 50, 0, nia, nrd);
    run_job(2, 8, 65, 1, 2, 50, 50, 0, nia, nrd);
    run_job(4, 8, 4, 2, 2, 50, 50, 0, nia, nrd);
    run_job(2, 8, 4, 2, 0, 50, 50, 0, nia, nrd);
    chk("illegal ia reads", nia, 0);

    run_job(2, 10, 4, 1, 2, 70, 70, 30, nia, nrd);
    run_job(3, 32, 64, 2, 2, 100, 100, 20, nia, nrd);

    reset_mid_run();
    run_job(3, 4, 2, 1, 1, 100, 100, 0, nia, nrd);

    for (int j = 0; j < 25; j++) begin
      if ($urandom_range(0, 5) == 0) begin
        kk = $urandom_range(0, 7); ww = $urandom_range(0, 63); occ = $urandom_range(0, 255);
        ss = $urandom_range(0, 7); rr = $urandom_range(0, 3);
      end else begin
        kk = $urandom_range(1, 3); ww = $urandom_range(4, 32); occ = $urandom_range(1, 64);
        ss = $urandom_range(1, 2); rr = $urandom_range(1, 3);
      end
      run_job(kk, ww, occ, ss, rr, $urandom_range(20, 100), $urandom_range(0, 100),
              $urandom_range(0, 30), nia, nrd);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
